// File: rtl/keypad_entry_if.sv
// keypad_entry_if: bundles the keypad event inputs, the entry valid/ready
// handshake and the display/status outputs of keypad_entry_ctrl.
//
// Handshake: entry_valid/entry_value/entry_len are driven by the controller
// and stay stable while entry_valid is high; a transfer happens on every
// rising clk edge where entry_valid && entry_ready, and entry_ready may be
// raised before entry_valid.
interface keypad_entry_if #(
    parameter int DIGITS = 4
);
    logic                  key_flag;
    logic [3:0]            key_value;
    logic                  entry_ready;
    logic                  entry_valid;
    logic [4*DIGITS-1:0]   entry_value;
    logic [3:0]            entry_len;
    logic [4*DIGITS-1:0]   disp_bcd;
    logic                  key_reject;
    logic                  timeout_pulse;
    logic                  busy;

    // Controller side
    modport master (
        input  key_flag, key_value, entry_ready,
        output entry_valid, entry_value, entry_len, disp_bcd,
               key_reject, timeout_pulse, busy
    );

    // Scanner / consumer side
    modport slave (
        output key_flag, key_value, entry_ready,
        input  entry_valid, entry_value, entry_len, disp_bcd,
               key_reject, timeout_pulse, busy
    );
endinterface

// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl: multi-digit BCD entry controller behind the 4x4 keypad
// scanner. Digits shift in at [3:0]; backspace, clear and enter edit the
// buffer; a completed entry is offered through a valid/ready handshake.
// Optional idle auto-abort is compiled in when KEY_ENTRY_TIMEOUT_EN is
// defined; otherwise timeout_pulse is constant 0.
module keypad_entry_ctrl #(
    parameter int DIGITS      = 4,
    parameter int TIMEOUT_CYC = 250_000_000
) (
    input  logic            clk,
    input  logic            rst_n,
    keypad_entry_if.master  bus,
    output logic [1:0]      dbg_state,
    output logic [3:0]      dbg_len
);
    localparam int W = 4 * DIGITS;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ENTRY  = 2'd1;
    localparam logic [1:0] ST_SUBMIT = 2'd2;

    logic [1:0]   state;
    logic         evt_pend;
    logic [W-1:0] digits_q;
    logic [3:0]   len_q;
    logic         entry_valid_q;
    logic [W-1:0] entry_value_q;
    logic [3:0]   entry_len_q;
    logic         key_reject_q;
    logic         timeout_pulse_q;
    logic         to_hit;

    logic is_digit, is_enter, is_clear, is_bksp;

    // Key code classification for the event being decoded this cycle
    always_comb begin
        is_digit = (bus.key_value <= 4'd9);
        is_enter = (bus.key_value == 4'hE);
        is_clear = (bus.key_value == 4'hF);
        is_bksp  = (bus.key_value == 4'hA);
    end

`ifdef KEY_ENTRY_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TW-1:0] to_cnt;

    // Expiry only when no key event competes; an event wins and reloads
    assign to_hit = (state == ST_ENTRY) && !evt_pend &&
                    (to_cnt == TW'(TIMEOUT_CYC - 1));

    // Idle counter: runs in ENTRY only, restarts on every key event
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (state != ST_ENTRY || evt_pend || to_hit) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    // Abort path absent; TIMEOUT_CYC has no effect in this build
    assign to_hit = 1'b0 & (TIMEOUT_CYC != 0);
`endif

    // Event capture, editing FSM, handshake and one-cycle status pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            evt_pend        <= 1'b0;
            digits_q        <= '0;
            len_q           <= 4'd0;
            entry_valid_q   <= 1'b0;
            entry_value_q   <= '0;
            entry_len_q     <= 4'd0;
            key_reject_q    <= 1'b0;
            timeout_pulse_q <= 1'b0;
        end else begin
            evt_pend        <= bus.key_flag;
            key_reject_q    <= 1'b0;
            timeout_pulse_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (evt_pend) begin
                        if (is_digit) begin
                            digits_q <= W'(bus.key_value);
                            len_q    <= 4'd1;
                            state    <= ST_ENTRY;
                        end else if (!is_clear) begin
                            key_reject_q <= 1'b1;
                        end
                    end
                end
                ST_ENTRY: begin
                    if (evt_pend) begin
                        if (is_digit) begin
                            if (len_q < 4'(DIGITS)) begin
                                digits_q <= (digits_q << 4) | W'(bus.key_value);
                                len_q    <= len_q + 4'd1;
                            end else begin
                                key_reject_q <= 1'b1;
                            end
                        end else if (is_bksp) begin
                            digits_q <= digits_q >> 4;
                            len_q    <= len_q - 4'd1;
                            if (len_q == 4'd1) begin
                                state <= ST_IDLE;
                            end
                        end else if (is_clear) begin
                            digits_q <= '0;
                            len_q    <= 4'd0;
                            state    <= ST_IDLE;
                        end else if (is_enter) begin
                            entry_value_q <= digits_q;
                            entry_len_q   <= len_q;
                            entry_valid_q <= 1'b1;
                            state         <= ST_SUBMIT;
                        end else begin
                            key_reject_q <= 1'b1;
                        end
                    end else if (to_hit) begin
                        digits_q        <= '0;
                        len_q           <= 4'd0;
                        timeout_pulse_q <= 1'b1;
                        state           <= ST_IDLE;
                    end
                end
                ST_SUBMIT: begin
                    // Keys are ignored until the entry has been taken
                    if (evt_pend) begin
                        key_reject_q <= 1'b1;
                    end
                    if (entry_valid_q && bus.entry_ready) begin
                        entry_valid_q <= 1'b0;
                        digits_q      <= '0;
                        len_q         <= 4'd0;
                        state         <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.entry_valid   = entry_valid_q;
    assign bus.entry_value   = entry_value_q;
    assign bus.entry_len     = entry_len_q;
    assign bus.disp_bcd      = digits_q;
    assign bus.key_reject    = key_reject_q;
    assign bus.timeout_pulse = timeout_pulse_q;
    assign bus.busy          = (state != ST_IDLE);
    assign dbg_state         = state;
    assign dbg_len           = len_q;
endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// tb_keypad_entry_ctrl: directed table, hand-written corner sequences and a
// randomized run against a digit-queue model of keypad_entry_ctrl.
module tb_keypad_entry_ctrl;
    localparam int DIGITS = 4;
    localparam int TO_CYC = 100;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;
    logic [3:0] dbg_len;

    keypad_entry_if #(.DIGITS(DIGITS)) bus ();

    keypad_entry_ctrl #(.DIGITS(DIGITS), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state),
        .dbg_len   (dbg_len)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Driver: flag in one cycle, code held for the decode cycle; returns at
    // the falling edge of the cycle where the result is visible.
    task automatic press(input logic [3:0] k);
        bus.key_flag  = 1'b1;
        bus.key_value = k;
        @(negedge clk);
        bus.key_flag  = 1'b0;
        @(negedge clk);
    endtask

    // Reference model: typed digits kept as a queue, oldest first
    int         mq[$];
    int         mmode;        // 0 waiting, 1 editing, 2 offering entry
    logic [15:0] mval;
    logic [3:0]  mlen;

    function automatic logic [15:0] model_bcd();
        logic [15:0] v;
        v = 16'h0;
        foreach (mq[i]) v = v + 16'(mq[i] * (16 ** (mq.size() - 1 - i)));
        return v;
    endfunction

    function automatic bit model_key(input logic [3:0] k);
        bit rej;
        rej = 1'b0;
        if (mmode == 2) begin
            rej = 1'b1;
        end else if (k <= 4'd9) begin
            if (mq.size() < DIGITS) begin
                mq.push_back(int'(k));
                mmode = 1;
            end else begin
                rej = 1'b1;
            end
        end else if (k == 4'hF) begin
            mq.delete();
            mmode = 0;
        end else if (mmode == 0) begin
            rej = 1'b1;
        end else if (k == 4'hA) begin
            void'(mq.pop_back());
            if (mq.size() == 0) mmode = 0;
        end else if (k == 4'hE) begin
            mval  = model_bcd();
            mlen  = 4'(mq.size());
            mmode = 2;
        end else begin
            rej = 1'b1;
        end
        return rej;
    endfunction

    typedef struct {
        logic [3:0]  key;
        logic        exp_rej;
        logic [15:0] exp_disp;
        logic [3:0]  exp_len;
        logic        exp_busy;
    } vec_t;

    vec_t vecs[21];
    int   found;
    int   pulses;
    bit   exp_rej;
    logic [3:0] k;
    int   r;

    initial begin
        vecs = '{
            '{4'hF, 1'b0, 16'h0000, 4'd0, 1'b0},
            '{4'hA, 1'b1, 16'h0000, 4'd0, 1'b0},
            '{4'hE, 1'b1, 16'h0000, 4'd0, 1'b0},
            '{4'hB, 1'b1, 16'h0000, 4'd0, 1'b0},
            '{4'h9, 1'b0, 16'h0009, 4'd1, 1'b1},
            '{4'h8, 1'b0, 16'h0098, 4'd2, 1'b1},
            '{4'h7, 1'b0, 16'h0987, 4'd3, 1'b1},
            '{4'h6, 1'b0, 16'h9876, 4'd4, 1'b1},
            '{4'h5, 1'b1, 16'h9876, 4'd4, 1'b1},
            '{4'hC, 1'b1, 16'h9876, 4'd4, 1'b1},
            '{4'hF, 1'b0, 16'h0000, 4'd0, 1'b0},
            '{4'h4, 1'b0, 16'h0004, 4'd1, 1'b1},
            '{4'h5, 1'b0, 16'h0045, 4'd2, 1'b1},
            '{4'hA, 1'b0, 16'h0004, 4'd1, 1'b1},
            '{4'h7, 1'b0, 16'h0047, 4'd2, 1'b1},
            '{4'hA, 1'b0, 16'h0004, 4'd1, 1'b1},
            '{4'hA, 1'b0, 16'h0000, 4'd0, 1'b0},
            '{4'h0, 1'b0, 16'h0000, 4'd1, 1'b1},
            '{4'h0, 1'b0, 16'h0000, 4'd2, 1'b1},
            '{4'hA, 1'b0, 16'h0000, 4'd1, 1'b1},
            '{4'hA, 1'b0, 16'h0000, 4'd0, 1'b0}
        };

        // Reset
        rst_n           = 1'b0;
        bus.key_flag    = 1'b0;
        bus.key_value   = 4'h0;
        bus.entry_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_valid", bus.entry_valid, 0);
        chk("rst_value", bus.entry_value, 0);
        chk("rst_len", bus.entry_len, 0);
        chk("rst_disp", bus.disp_bcd, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_state", dbg_state, 0);

        // Directed editing table
        for (int i = 0; i < 21; i++) begin
            press(vecs[i].key);
            chk($sformatf("vec%0d_rej", i), bus.key_reject, vecs[i].exp_rej);
            chk($sformatf("vec%0d_disp", i), bus.disp_bcd, vecs[i].exp_disp);
            chk($sformatf("vec%0d_len", i), dbg_len, vecs[i].exp_len);
            chk($sformatf("vec%0d_busy", i), bus.busy, vecs[i].exp_busy);
        end

        // 1,2,3,# with ready already high: one-cycle valid
        bus.entry_ready = 1'b1;
        press(4'h1); press(4'h2); press(4'h3); press(4'hE);
        chk("ent_valid", bus.entry_valid, 1);
        chk("ent_value", bus.entry_value, 16'h0123);
        chk("ent_len", bus.entry_len, 3);
        @(negedge clk);
        chk("ent_valid_drop", bus.entry_valid, 0);
        chk("ent_idle_busy", bus.busy, 0);
        chk("ent_idle_disp", bus.disp_bcd, 0);
        chk("ent_value_hold", bus.entry_value, 16'h0123);
        bus.entry_ready = 1'b0;

        // 9876 then enter, ready low: back-pressure and reject in SUBMIT
        press(4'h9); press(4'h8); press(4'h7); press(4'h6); press(4'hE);
        chk("full_value", bus.entry_value, 16'h9876);
        chk("full_len", bus.entry_len, 4);
        press(4'h3);
        chk("sub_rej", bus.key_reject, 1);
        chk("sub_disp", bus.disp_bcd, 16'h9876);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("sub_hold_valid", bus.entry_valid, 1);
            chk("sub_hold_value", bus.entry_value, 16'h9876);
        end
        bus.entry_ready = 1'b1;
        @(negedge clk);
        bus.entry_ready = 1'b0;
        chk("sub_release_valid", bus.entry_valid, 0);
        chk("sub_release_busy", bus.busy, 0);
        chk("sub_release_len", bus.entry_len, 4);

        // Key event landing on the transfer edge is rejected
        press(4'h1); press(4'h2); press(4'hE);
        chk("x_value", bus.entry_value, 16'h0012);
        bus.key_flag  = 1'b1;
        bus.key_value = 4'h5;
        @(negedge clk);
        bus.key_flag    = 1'b0;
        bus.entry_ready = 1'b1;
        @(negedge clk);
        bus.entry_ready = 1'b0;
        chk("x_rej", bus.key_reject, 1);
        chk("x_valid", bus.entry_valid, 0);
        chk("x_busy", bus.busy, 0);
        chk("x_disp", bus.disp_bcd, 0);

        // Key flags one cycle apart are both taken
        bus.key_flag  = 1'b1;
        bus.key_value = 4'h3;
        @(negedge clk);
        @(negedge clk);
        bus.key_flag  = 1'b0;
        bus.key_value = 4'h4;
        @(negedge clk);
        chk("b2b_disp", bus.disp_bcd, 16'h0034);
        chk("b2b_len", dbg_len, 2);
        press(4'hF);
        chk("b2b_clear", bus.busy, 0);

        // Idle timeout
        press(4'h7);
        chk("to_busy0", bus.busy, 1);
        found  = -1;
        pulses = 0;
`ifdef KEY_ENTRY_TIMEOUT_EN
        for (int i = 1; i <= 1000 && found < 0; i++) begin
            @(negedge clk);
            if (bus.timeout_pulse) found = i;
        end
        chk("to_cycle", found, TO_CYC);
        chk("to_busy", bus.busy, 0);
        chk("to_disp", bus.disp_bcd, 0);
        @(negedge clk);
        chk("to_pulse_width", bus.timeout_pulse, 0);
`else
        for (int i = 1; i <= 1000; i++) begin
            @(negedge clk);
            if (bus.timeout_pulse) pulses++;
        end
        chk("to_pulses", pulses, 0);
        chk("to_busy", bus.busy, 1);
        chk("to_disp", bus.disp_bcd, 16'h0007);
        press(4'hF);
`endif

        // Reset while offering an entry
        press(4'h1); press(4'hE);
        chk("rs_valid_pre", bus.entry_valid, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rs_valid", bus.entry_valid, 0);
        chk("rs_value", bus.entry_value, 0);
        chk("rs_len", bus.entry_len, 0);
        chk("rs_disp", bus.disp_bcd, 0);
        chk("rs_busy", bus.busy, 0);
        chk("rs_state", dbg_state, 0);
        @(negedge clk);

        // Randomized run against the queue model
        mq.delete();
        mmode = 0;
        mval  = 16'h0;
        mlen  = 4'd0;
        for (int n = 0; n < 400; n++) begin
            if (mmode == 2 && $urandom_range(0, 2) == 0) begin
                bus.entry_ready = 1'b1;
                @(negedge clk);
                bus.entry_ready = 1'b0;
                mq.delete();
                mmode = 0;
                chk("rnd_xfer_valid", bus.entry_valid, 0);
                chk("rnd_xfer_busy", bus.busy, 0);
                chk("rnd_xfer_disp", bus.disp_bcd, 0);
            end else begin
                r = $urandom_range(0, 9);
                if (r < 6)       k = 4'($urandom_range(0, 9));
                else if (r == 6) k = 4'hA;
                else if (r == 7) k = 4'hE;
                else if (r == 8) k = 4'hF;
                else             k = 4'($urandom_range(11, 13));
                exp_rej = model_key(k);
                press(k);
                chk("rnd_rej", bus.key_reject, exp_rej);
                chk("rnd_disp", bus.disp_bcd, model_bcd());
                chk("rnd_len", dbg_len, 4'(mq.size()));
                chk("rnd_busy", bus.busy, mmode != 0);
                chk("rnd_valid", bus.entry_valid, mmode == 2);
                if (mmode == 2) begin
                    chk("rnd_value", bus.entry_value, mval);
                    chk("rnd_elen", bus.entry_len, mlen);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
